// File: rtl/bnn_pix_packer.sv
// Binarizes a serial pixel stream against a threshold and packs WIDTH0 pixels per vector.
// A full frame loads vecX one edge after its last beat; a second frame waits in asm and stalls pix_ready.
module bnn_pix_packer #(
   parameter int WIDTH0 = 784,
   parameter int PIX_W  = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PIX_W-1:0]  thresh,
   input  logic [PIX_W-1:0]  pix,
   input  logic              pix_sof,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic [WIDTH0-1:0] vecX,
   output logic              vecX_valid,
   input  logic              vecX_ready,
   output logic [CNT_W-1:0]  drop_cnt
);
   localparam int IDX_W = (WIDTH0 > 1) ? $clog2(WIDTH0) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH0 - 1);

   logic [WIDTH0-1:0] asmVec;
   logic [WIDTH0-1:0] asmNext;
   logic              asmFull;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  curIdx;
   logic              accept;
   logic              pixBit;
   logic              midSof;
   logic              lastBeat;
   logic              slotFree;

   assign pix_ready = !asmFull;
   assign accept    = pix_valid && !asmFull;
   assign pixBit    = (pix >= thresh);
   // A mid-frame SOF restarts packing with this beat as pixel 0.
   assign midSof    = accept && pix_sof && (idx != '0);
   assign curIdx    = midSof ? '0 : idx;
   assign lastBeat  = accept && (curIdx == LAST_IDX);
   assign slotFree  = !vecX_valid || vecX_ready;

   always_comb begin
      asmNext         = asmVec;
      asmNext[curIdx] = pixBit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         asmVec     <= '0;
         asmFull    <= 1'b0;
         idx        <= '0;
         drop_cnt   <= '0;
         vecX       <= '0;
         vecX_valid <= 1'b0;
      end else begin
         if (accept) begin
            asmVec <= asmNext;
            idx    <= lastBeat ? '0 : curIdx + IDX_W'(1);
            if (midSof && (drop_cnt != '1))
               drop_cnt <= drop_cnt + CNT_W'(1);
         end

         // asmFull implies vecX_valid, so a ready consumer always frees the slot here.
         if (asmFull && vecX_ready) begin
            vecX       <= asmVec;
            vecX_valid <= 1'b1;
            asmFull    <= 1'b0;
         end else if (lastBeat && slotFree) begin
            vecX       <= asmNext;
            vecX_valid <= 1'b1;
         end else if (lastBeat) begin
            asmFull    <= 1'b1;
         end else if (vecX_valid && vecX_ready) begin
            vecX_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bnn_pix_packer.sv
// Randomized and directed bench for bnn_pix_packer with a frame-level queue model.
module tb_bnn_pix_packer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  thresh = 8'd128;
   logic [7:0]  pix = 8'd0;
   logic        pix_sof = 1'b0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [15:0] vecX;
   logic        vecX_valid;
   logic        vecX_ready = 1'b0;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   // Model: bits of the frame in progress, and vectors awaiting the consumer (head = vecX).
   bit          fr[$];
   logic [15:0] mq[$];
   int          mDrop = 0;

   always #5 clk = ~clk;

   bnn_pix_packer #(.WIDTH0(16), .PIX_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .thresh(thresh), .pix(pix), .pix_sof(pix_sof),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .vecX(vecX),
      .vecX_valid(vecX_valid), .vecX_ready(vecX_ready), .drop_cnt(drop_cnt)
   );

   task automatic modelClear();
      fr.delete();
      mq.delete();
      mDrop = 0;
   endtask

   // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
   task automatic tick(input bit pv, input bit sof, input logic [7:0] p,
                       input logic [7:0] th, input bit vr);
      bit          acc;
      logic [15:0] v;
      pix_valid  = pv;
      pix_sof    = sof;
      pix        = p;
      thresh     = th;
      vecX_ready = vr;
      acc = pv && (mq.size() < 2);
      @(posedge clk);
      if (vr && mq.size() > 0) mq.delete(0);
      if (acc) begin
         if (sof && fr.size() != 0) begin
            fr.delete();
            if (mDrop < 255) mDrop++;
         end
         fr.push_back(p >= th);
         if (fr.size() == 16) begin
            for (int k = 0; k < 16; k++) v[k] = fr[k];
            mq.push_back(v);
            fr.delete();
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++; if (vecX !== 16'h0) begin errors++; $display("FAIL reset_vecX got %h want 0000", vecX); end
      checks++; if (vecX_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vecX_valid); end
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", pix_ready); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
      modelClear();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      for (int k = 0; k < 16; k++) begin
         checks++; if (vecX_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d got %b want 0", k, vecX_valid); end
         tick(1'b1, k == 0, (k % 2 == 0) ? 8'hFF : 8'h00, 8'd128, 1'b1);
      end
      checks++; if (vecX_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", vecX_valid); end
      checks++; if (vecX !== 16'h5555) begin errors++; $display("FAIL basic_vec got %h want 5555", vecX); end
      tick(1'b0, 1'b0, 8'h00, 8'd128, 1'b1);
      checks++; if (vecX_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", vecX_valid); end
   endtask

   task automatic test_threshold();
      logic [7:0] pat [4];
      pat[0] = 8'd127; pat[1] = 8'd128; pat[2] = 8'd129; pat[3] = 8'd0;
      for (int k = 0; k < 16; k++) tick(1'b1, k == 0, pat[k % 4], 8'd128, 1'b1);
      checks++; if (vecX_valid !== 1'b1) begin errors++; $display("FAIL thresh_valid got %b want 1", vecX_valid); end
      checks++; if (vecX !== 16'h6666) begin errors++; $display("FAIL thresh_vec got %h want 6666", vecX); end
      // thresh = 0 forces every bit to 1
      for (int k = 0; k < 16; k++) tick(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'd0, 1'b1);
      checks++; if (vecX !== 16'hFFFF) begin errors++; $display("FAIL thresh_zero got %h want ffff", vecX); end
      tick(1'b0, 1'b0, 8'h00, 8'd128, 1'b1);
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int lastCyc = -1;
      int readyLow = 0;
      for (int c = 0; c < 48; c++) begin
         if (pix_ready !== 1'b1) readyLow++;
         tick(1'b1, (c % 16) == 0, 8'((c % 16) * 16), 8'd128, 1'b1);
         if (vecX_valid === 1'b1) begin
            pulses++;
            checks++; if (vecX !== 16'hFF00) begin errors++; $display("FAIL b2b_vec got %h want ff00", vecX); end
            if (lastCyc >= 0) begin
               checks++; if (c - lastCyc !== 16) begin errors++; $display("FAIL b2b_spacing got %0d want 16", c - lastCyc); end
            end
            lastCyc = c;
         end
      end
      checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
      checks++; if (readyLow !== 0) begin errors++; $display("FAIL b2b_ready_low got %0d want 0", readyLow); end
      tick(1'b0, 1'b0, 8'h00, 8'd128, 1'b1);
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 32; k++) begin
         checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_early beat %0d got %b want 1", k, pix_ready); end
         tick(1'b1, (k % 16) == 0, (k < 8 || k >= 16) ? 8'hF0 : 8'h10, 8'd128, 1'b0);
      end
      checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b want 0", pix_ready); end
      checks++; if (vecX !== 16'h00FF) begin errors++; $display("FAIL bp_hold got %h want 00ff", vecX); end
      tick(1'b1, 1'b0, 8'h00, 8'd128, 1'b0);
      checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b want 0", pix_ready); end
      checks++; if (vecX !== 16'h00FF || vecX_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_hold got %h/%b want 00ff/1", vecX, vecX_valid); end
      tick(1'b0, 1'b0, 8'h00, 8'd128, 1'b1);
      checks++; if (vecX !== 16'hFFFF || vecX_valid !== 1'b1) begin errors++; $display("FAIL bp_release got %h/%b want ffff/1", vecX, vecX_valid); end
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", pix_ready); end
      tick(1'b0, 1'b0, 8'h00, 8'd128, 1'b1);
      checks++; if (vecX_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", vecX_valid); end
   endtask

   task automatic test_mid_sof();
      int vecs = 0;
      for (int k = 0; k < 6; k++) tick(1'b1, k == 0, 8'($urandom_range(0, 255)), 8'd128, 1'b1);
      for (int k = 0; k < 16; k++) begin
         tick(1'b1, k == 0, 8'hFF, 8'd128, 1'b1);
         if (vecX_valid === 1'b1) begin
            vecs++;
            checks++; if (vecX !== 16'hFFFF) begin errors++; $display("FAIL sof_vec got %h want ffff", vecX); end
         end
      end
      tick(1'b0, 1'b0, 8'h00, 8'd128, 1'b1);
      checks++; if (vecs !== 1) begin errors++; $display("FAIL sof_vec_count got %0d want 1", vecs); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL sof_drop got %0d want 1", drop_cnt); end
      for (int k = 0; k < 301; k++) begin
         tick(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'd128, 1'b1);
         if (k == 100) begin
            checks++; if (drop_cnt !== 8'(mDrop)) begin errors++; $display("FAIL sof_drop_mid got %0d want %0d", drop_cnt, mDrop); end
         end
      end
      checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sof_saturate got %0d want 255", drop_cnt); end
   endtask

   task automatic test_reset_midframe();
      for (int k = 0; k < 9; k++) tick(1'b1, k == 0, 8'($urandom_range(0, 255)), 8'd128, 1'b1);
      pix_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++; if (vecX !== 16'h0) begin errors++; $display("FAIL rstmid_vecX got %h want 0000", vecX); end
      checks++; if (vecX_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", vecX_valid); end
      checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", pix_ready); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_drop got %0d want 0", drop_cnt); end
      modelClear();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 16; k++) tick(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'd128, 1'b1);
      checks++; if (vecX_valid !== 1'b1 || mq.size() != 1) begin errors++; $display("FAIL rstmid_frame_valid got %b want 1", vecX_valid); end
      else begin
         checks++; if (vecX !== mq[0]) begin errors++; $display("FAIL rstmid_frame_vec got %h want %h", vecX, mq[0]); end
      end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_frame_drop got %0d want 0", drop_cnt); end
      tick(1'b0, 1'b0, 8'h00, 8'd128, 1'b1);
   endtask

   task automatic test_random();
      bit expRdy;
      for (int c = 0; c < 600; c++) begin
         expRdy = (mq.size() < 2);
         checks++; if (vecX_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %0d", c, vecX_valid, mq.size() > 0); end
         if (mq.size() > 0) begin
            checks++; if (vecX !== mq[0]) begin errors++; $display("FAIL rand_vec cyc %0d got %h want %h", c, vecX, mq[0]); end
         end
         checks++; if (pix_ready !== expRdy) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", c, pix_ready, expRdy); end
         checks++; if (drop_cnt !== 8'(mDrop)) begin errors++; $display("FAIL rand_drop cyc %0d got %0d want %0d", c, drop_cnt, mDrop); end
         tick($urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0, 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), $urandom_range(0, 9) < 5);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_threshold();
      test_back_to_back();
      test_backpressure();
      test_mid_sof();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bnn_pix_packer.md
# bnn_pix_packer

Input stage placed directly upstream of `bnn_pipe12`. It accepts a serial stream of 8-bit grey-level pixels with a valid/ready handshake and binarizes each pixel against a programmable threshold. It packs `WIDTH0` consecutive pixels into one input vector `vecX` and presents each completed vector for exactly one accepted transfer. Double buffering lets the next frame be assembled while the previous vector waits for the consumer.

## Interface

**Parameters**
- `WIDTH0`, default 784: bits per packed vector (pixels per frame); must match `bnn_pipe12`'s `WIDTH0`.
- `PIX_W`, default 8: pixel sample width.
- `CNT_W`, default 8: width of the saturating drop counter.

**Ports**
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `thresh`, in, `PIX_W`: binarization threshold, sampled on every accepted beat.
- `pix`, in, `PIX_W`: pixel sample.
- `pix_sof`, in, 1: start of frame, qualified by `pix_valid`.
- `pix_valid`, in, 1: beat valid.
- `pix_ready`, out, 1: beat accepted when `pix_valid && pix_ready`.
- `vecX`, out, `WIDTH0`: packed binarized vector.
- `vecX_valid`, out, 1: `vecX` holds an unconsumed vector.
- `vecX_ready`, in, 1: consumer accepts; tie to 1 when feeding `bnn_pipe12` directly.
- `drop_cnt`, out, `CNT_W`: number of frames aborted by a mid-frame `pix_sof`, saturating.

## Operation

- **Binarization:** bit = 1 iff `pix >= thresh`, as an unsigned compare.
  - `thresh = 0` makes every bit 1.
- **Packing:** the k-th accepted pixel of a frame (k = 0..`WIDTH0`-1) lands in `vecX[k]`.
  - Pixel 0 is the LSB.
- **Pixel index `idx`:** counts 0..`WIDTH0`-1 and wraps to 0 after the last pixel is accepted.
- **Assembly register `asm`** (`WIDTH0` bits) and flag `asm_full`:
  - When the last pixel is accepted and the output slot is free (`!vecX_valid || vecX_ready`), the completed vector loads straight into `vecX`. `asm_full` stays 0.
  - When the last pixel is accepted and the output slot is not free, `asm_full` is set.
  - While `asm_full` is set, the completed vector moves to `vecX` on the first edge where `vecX_ready` is high. `asm_full` clears on that edge.
- **Input ready:** `pix_ready = !asm_full` (combinational from the flag).
- **Output:** `vecX_valid` sets when a vector loads. It clears on `vecX_valid && vecX_ready` unless a new vector loads on the same edge, in which case it stays 1 with the new data.
  - `vecX` is held stable while `vecX_valid && !vecX_ready`.
- **SOF handling:**
  - `pix_sof` on an accepted beat with `idx == 0` is normal.
  - `pix_sof` on an accepted beat with `idx != 0` discards the partial frame and increments `drop_cnt` (saturating at all-ones). That beat becomes pixel 0 of a new frame, and `idx` becomes 1 after the edge.
  - A beat at `idx == 0` without `pix_sof` is accepted normally; `pix_sof` is optional.
- **Unused `asm` bits:** bits above `idx` may hold stale data. Only complete frames are ever transferred to `vecX`.

## Timing

- **Reset values** (async assertion, synchronous release): `vecX` = 0, `vecX_valid` = 0, `asm_full` = 0, `pix_ready` = 1, `idx` = 0, `drop_cnt` = 0.
- **Reset mid-frame:** the partial frame is lost and is not counted in `drop_cnt`.
- **Latency:** the last pixel accepted at edge N gives `vecX_valid` = 1 after edge N when the slot is free.
- **Throughput:** one pixel per cycle sustained with `vecX_ready` = 1. Back-to-back frames give a `vecX_valid` pulse every `WIDTH0` cycles.
- **Backpressure:** with `vecX_ready` = 0, one complete frame buffers in `asm`. `pix_ready` falls the cycle after the second frame completes and rises the cycle after `vecX_ready` is seen high.
- **Same-edge events:** `vecX` consumed on the same edge the last pixel is accepted → the new vector loads and `vecX_valid` stays 1.
- **`thresh` changes mid-frame:** each pixel uses the `thresh` value present on its own accepted beat.

## Test plan

All scenarios use `WIDTH0 = 16` and `thresh = 128`.

1. **Basic pack:** 16 beats alternating `pix` 0xFF/0x00, starting with 0xFF and `pix_sof` on the first beat, `vecX_ready` = 1 → one `vecX_valid` pulse the cycle after beat 16, with `vecX` = 16'h5555.
2. **Threshold edge:** pixels 127, 128, 129, 0 repeated ×4 → `vecX` = 16'h6666.
3. **Back-to-back:** 3 frames streamed continuously with ramp pixels `k*16` → three `vecX_valid` pulses exactly 16 cycles apart, each `vecX` = 16'hFF00, and `pix_ready` never low.
4. **Backpressure:** hold `vecX_ready` = 0 and stream 2 frames (16'h00FF, then 16'hFFFF).
   - `vecX` holds 16'h00FF.
   - `pix_ready` drops after beat 32; a 33rd beat is stalled.
   - Raising `vecX_ready` presents 16'hFFFF on the next cycle, then `pix_ready` returns to 1.
5. **Mid-frame SOF:** assert `pix_sof` on beat 6, then send 16 beats of 0xFF → `drop_cnt` = 1 and the only vector produced is 16'hFFFF. Repeat 300 aborts → `drop_cnt` saturates at 255.
6. **Reset mid-frame:** drive `rst` low after 9 beats → all outputs return to their reset values immediately. A fresh 16-beat frame then produces the correct vector with `drop_cnt` = 0.
